// File: rtl/div_unit.sv
// RV32M divide/remainder unit: radix-2 restoring divider, one quotient bit per cycle.
// It stalls the front of the pipeline while busy and short-circuits divide-by-zero and signed overflow.
module div_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic        flush,
  output logic        stall,
  output logic        result_valid,
  output logic [31:0] result
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t      state_r, state_s;
  logic [4:0]  count_r;
  logic        is_rem_r, q_neg_r, r_neg_r;
  logic [31:0] divisor_r, quot_r, result_r;
  logic [32:0] rem_r;

  logic        accept_s, is_signed_s, special_s;
  logic [31:0] a_abs_s, b_abs_s, special_res_s, quot_nx_s, final_s;
  logic [32:0] rem_shift_s, rem_nx_s;

  function automatic logic [31:0] neg32(input logic [31:0] v);
    return (~v) + 32'd1;
  endfunction

  // Acceptance decode, operand conditioning and the special-case results
  always_comb begin
    accept_s      = (state_r == IDLE) && start && funct3[2] && !flush;
    is_signed_s   = ~funct3[0];
    a_abs_s       = rs1_data;
    b_abs_s       = rs2_data;
    special_s     = 1'b0;
    special_res_s = 32'd0;
    if (is_signed_s && rs1_data[31]) a_abs_s = neg32(rs1_data);
    else                             a_abs_s = rs1_data;
    if (is_signed_s && rs2_data[31]) b_abs_s = neg32(rs2_data);
    else                             b_abs_s = rs2_data;
    if (rs2_data == 32'd0) begin
      special_s     = 1'b1;
      special_res_s = funct3[1] ? rs1_data : 32'hFFFF_FFFF;
    end else if (is_signed_s && (rs1_data == 32'h8000_0000) && (rs2_data == 32'hFFFF_FFFF)) begin
      special_s     = 1'b1;
      special_res_s = funct3[1] ? 32'd0 : 32'h8000_0000;
    end else begin
      special_s     = 1'b0;
      special_res_s = 32'd0;
    end
  end

  // One restoring step, plus sign correction of the final quotient/remainder
  always_comb begin
    rem_shift_s = {rem_r[31:0], quot_r[31]};
    if (rem_shift_s >= {1'b0, divisor_r}) begin
      rem_nx_s  = rem_shift_s - {1'b0, divisor_r};
      quot_nx_s = {quot_r[30:0], 1'b1};
    end else begin
      rem_nx_s  = rem_shift_s;
      quot_nx_s = {quot_r[30:0], 1'b0};
    end
    if (is_rem_r) final_s = r_neg_r ? neg32(rem_nx_s[31:0]) : rem_nx_s[31:0];
    else          final_s = q_neg_r ? neg32(quot_nx_s) : quot_nx_s;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_s;
  end

  // Next-state logic; flush overrides every transition
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    state_s = accept_s ? (special_s ? DONE : BUSY) : IDLE;
      BUSY:    state_s = (count_r == 5'd31) ? DONE : BUSY;
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
    if (flush) state_s = IDLE;
    else       state_s = state_s;
  end

  // Outputs decoded from state; stall is suppressed by flush and by reset
  always_comb begin
    result_valid = (state_r == DONE);
    stall        = rst_n && !flush && (accept_s || (state_r == BUSY));
    result       = result_r;
  end

  // Datapath registers: operand latch on acceptance, iterate in BUSY
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r   <= 5'd0;
      is_rem_r  <= 1'b0;
      q_neg_r   <= 1'b0;
      r_neg_r   <= 1'b0;
      divisor_r <= 32'd0;
      quot_r    <= 32'd0;
      rem_r     <= 33'd0;
      result_r  <= 32'd0;
    end else if (accept_s) begin
      count_r   <= 5'd0;
      is_rem_r  <= funct3[1];
      q_neg_r   <= is_signed_s && (rs1_data[31] ^ rs2_data[31]);
      r_neg_r   <= is_signed_s && rs1_data[31];
      divisor_r <= b_abs_s;
      quot_r    <= a_abs_s;
      rem_r     <= 33'd0;
      if (special_s) result_r <= special_res_s;
    end else if ((state_r == BUSY) && !flush) begin
      count_r <= count_r + 5'd1;
      quot_r  <= quot_nx_s;
      rem_r   <= rem_nx_s;
      if (count_r == 5'd31) result_r <= final_s;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: expected results queued at issue, popped and checked at result_valid.
module tb_div_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] rs1_data, rs2_data;
  logic        flush;
  logic        stall, result_valid;
  logic [31:0] result;

  int passed = 0;
  int total  = 0;
  logic [31:0] exp_q[$];

  localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;

  div_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .flush(flush),
    .stall(stall), .result_valid(result_valid), .result(result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Issue one op in the next cycle, hold start while stalled, check latency, stall count and result.
  task automatic do_op(input string tag, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat);
    int cyc, stall_cnt;
    @(negedge clk);
    start = 1'b1; funct3 = f3; rs1_data = a; rs2_data = b;
    exp_q.push_back(exp);
    #1;
    chk({tag, "_rv_before"}, {31'd0, result_valid}, 32'd0);
    cyc = 0; stall_cnt = 0;
    while (result_valid !== 1'b1 && cyc < 40) begin
      if (stall === 1'b1) stall_cnt++;
      @(negedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    chk({tag, "_latency"}, cyc, lat);
    chk({tag, "_stall_cycles"}, stall_cnt, lat);
    chk({tag, "_stall_done"}, {31'd0, stall}, 32'd0);
    chk({tag, "_result"}, result, exp_q.pop_front());
  endtask

  initial begin
    int seen;
    rst_n = 1'b0; start = 1'b1; funct3 = F_DIVU; rs1_data = 32'd100; rs2_data = 32'd7; flush = 1'b0;
    #1;
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_rv", {31'd0, result_valid}, 32'd0);
    chk("rst_result", result, 32'd0);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    do_op("divu_100_7", F_DIVU, 32'd100, 32'd7, 32'd14, 33);
    do_op("remu_100_7", F_REMU, 32'd100, 32'd7, 32'd2, 33);
    do_op("div_m100_7", F_DIV, -32'sd100, 32'd7, 32'hFFFF_FFF2, 33);
    do_op("rem_m100_7", F_REM, -32'sd100, 32'd7, 32'hFFFF_FFFE, 33);
    do_op("div_100_m7", F_DIV, 32'd100, -32'sd7, 32'hFFFF_FFF2, 33);
    do_op("rem_100_m7", F_REM, 32'd100, -32'sd7, 32'd2, 33);
    do_op("div_5_0", F_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    do_op("rem_5_0", F_REM, 32'd5, 32'd0, 32'd5, 1);
    do_op("divu_5_0", F_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    do_op("remu_5_0", F_REMU, 32'd5, 32'd0, 32'd5, 1);
    do_op("div_ovf", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    do_op("rem_ovf", F_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
    do_op("divu_big", F_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33);
    do_op("rem_m7_m3", F_REM, -32'sd7, -32'sd3, -32'sd1, 33);

    // Non-divide funct3 and a flushed start are both ignored
    @(negedge clk);
    start = 1'b1; funct3 = 3'b000; rs1_data = 32'd9; rs2_data = 32'd3; #1;
    chk("nondiv_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    funct3 = F_DIVU; flush = 1'b1; #1;
    chk("flush_accept_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    seen = 0;
    repeat (40) begin @(negedge clk); #1; if (result_valid === 1'b1) seen++; end
    chk("ignored_no_rv", seen, 0);

    // Flush at BUSY counter=10 (cycle T+11)
    @(negedge clk);
    start = 1'b1; funct3 = F_DIVU; rs1_data = 32'd1000; rs2_data = 32'd3;
    repeat (11) @(negedge clk);
    #1;
    chk("busy_stall", {31'd0, stall}, 32'd1);
    start = 1'b0; flush = 1'b1; #1;
    chk("flush_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    flush = 1'b0; #1;
    chk("after_flush_stall", {31'd0, stall}, 32'd0);
    seen = 0;
    repeat (40) begin if (result_valid === 1'b1) seen++; @(negedge clk); #1; end
    chk("flush_no_rv", seen, 0);

    // Reset at BUSY counter=20 (cycle T+21)
    @(negedge clk);
    start = 1'b1; funct3 = F_DIVU; rs1_data = 32'd12345; rs2_data = 32'd7;
    repeat (21) @(negedge clk);
    rst_n = 1'b0; #1;
    chk("midrst_stall", {31'd0, stall}, 32'd0);
    chk("midrst_rv", {31'd0, result_valid}, 32'd0);
    chk("midrst_result", result, 32'd0);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    do_op("divu_max_1", F_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33);
    do_op("divu_9_3", F_DIVU, 32'd9, 32'd3, 32'd3, 33);
    @(negedge clk); #1;
    chk("rv_one_cycle", {31'd0, result_valid}, 32'd0);
    chk("result_held", result, 32'd3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
